// File: rtl/exe_mult_unit.sv
// exe_mult_unit: iterative shift-add signed multiplier that stalls the pipeline and commits the product to HI/LO
module exe_mult_unit #(
  parameter int WORD_LEN = 32,
  parameter int EXE_CMD_LEN = 4,
  parameter logic [EXE_CMD_LEN-1:0] MULT_CMD = 4'd10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXE_CMD_LEN-1:0] exe_cmd,
  input  logic                   valid,
  input  logic                   flush,
  input  logic [WORD_LEN-1:0]    val1,
  input  logic [WORD_LEN-1:0]    val2,
  output logic                   stall,
  output logic                   done,
  output logic [WORD_LEN-1:0]    hi,
  output logic [WORD_LEN-1:0]    lo
);
  localparam int CW = $clog2(WORD_LEN);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [2*WORD_LEN-1:0] mcand, acc, acc_nxt;
  logic [WORD_LEN-1:0] mplier, abs1, abs2;
  logic [CW-1:0] count;
  logic neg, start, last;
  always_comb begin
    start = valid && exe_cmd == MULT_CMD && !flush;
    abs1 = val1[WORD_LEN-1] ? -val1 : val1;
    abs2 = val2[WORD_LEN-1] ? -val2 : val2;
    acc_nxt = acc + (mplier[0] ? mcand : '0);
    last = count == CW'(WORD_LEN - 1);
    stall = state == IDLE ? start : state == RUN && !flush;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hi <= '0;
      lo <= '0;
      count <= '0;
      done <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      neg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand <= {{WORD_LEN{1'b0}}, abs1};
          mplier <= abs2;
          neg <= val1[WORD_LEN-1] ^ val2[WORD_LEN-1];
          acc <= '0;
          count <= '0;
          state <= RUN;
        end
        RUN: if (flush) state <= IDLE;
        else begin
          acc <= acc_nxt;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          count <= count + 1'b1;
          if (last) begin
            {hi, lo} <= neg ? -acc_nxt : acc_nxt;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_mult_unit.sv
// tb_exe_mult_unit: table, random and corner-sequence checks of exe_mult_unit against a signed-product model
module tb_exe_mult_unit;
  localparam logic [3:0] MULT = 4'd10;
  localparam logic [3:0] ADD = 4'd1;
  logic clk = 0, rst = 1, valid = 0, flush = 0, stall, done;
  logic [3:0] exe_cmd = '0;
  logic [31:0] val1 = '0, val2 = '0, hi, lo;
  int n_cmp = 0, n_bad = 0;

  exe_mult_unit dut (.clk(clk), .rst(rst), .exe_cmd(exe_cmd), .valid(valid), .flush(flush),
                     .val1(val1), .val2(val2), .stall(stall), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a, b, ehi, elo;} vec_t;
  vec_t tbl[4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one MULT from IDLE; chain=1 presents the next MULT during the DONE cycle.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit chain,
                          input logic [31:0] na, input logic [31:0] nb);
    int sc, done_at;
    logic [63:0] exp;
    exp = model(a, b);
    exe_cmd = MULT; valid = 1; flush = 0; val1 = a; val2 = b;
    sc = 0; done_at = -1;
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      #1;
      if (stall) sc++;
      if (done) begin
        done_at = k;
        if (chain) begin
          val1 = na; val2 = nb;
          #1 chk("stall_done_with_start", {63'b0, stall}, 64'd0);
        end else valid = 0;
      end else if (k > 0) begin
        val1 = $urandom; val2 = $urandom;
      end
      tick();
    end
    chk("stall_cycles", 64'(sc), 64'd33);
    chk("done_cycle", 64'(done_at), 64'd33);
    chk("product", {hi, lo}, exp);
  endtask

  initial begin
    logic [63:0] prior;
    tbl[0] = '{32'd3, 32'd5, 32'h0, 32'hF};
    tbl[1] = '{32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA};
    tbl[2] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
    tbl[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    tick(); tick();
    rst = 0;
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_stall_done", {62'b0, stall, done}, 64'd0);

    foreach (tbl[i]) begin
      chk("table_model", model(tbl[i].a, tbl[i].b), {tbl[i].ehi, tbl[i].elo});
      run_mult(tbl[i].a, tbl[i].b, 0, 0, 0);
      chk("table_hilo", {hi, lo}, {tbl[i].ehi, tbl[i].elo});
    end

    for (int r = 0; r < 8; r++) run_mult($urandom, $urandom, 0, 0, 0);

    // flush on the 10th RUN cycle
    prior = {hi, lo};
    exe_cmd = MULT; valid = 1; val1 = 7; val2 = 9;
    tick();
    for (int k = 1; k < 10; k++) tick();
    flush = 1;
    #1 chk("stall_in_flush", {63'b0, stall}, 64'd0);
    tick();
    flush = 0; valid = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) chk("no_done_after_flush", 64'd1, 64'd0);
      tick();
    end
    chk("hilo_after_flush", {hi, lo}, prior);
    run_mult(32'd11, 32'hFFFFFFF3, 0, 0, 0);

    // flush on the accept cycle
    prior = {hi, lo};
    exe_cmd = MULT; valid = 1; flush = 1; val1 = 100; val2 = 100;
    #1 chk("stall_accept_flush", {63'b0, stall}, 64'd0);
    tick();
    flush = 0; valid = 0;
    for (int k = 0; k < 36; k++) begin
      if (done || stall) chk("idle_after_accept_flush", {62'b0, stall, done}, 64'd0);
      tick();
    end
    chk("hilo_accept_flush", {hi, lo}, prior);

    // back-to-back
    run_mult(32'd6, 32'd7, 1, 32'hFFFFFFFC, 32'd5);
    chk("b2b_first_lo", {32'b0, lo}, 64'd42);
    run_mult(32'hFFFFFFFC, 32'd5, 0, 0, 0);
    chk("b2b_second", {hi, lo}, 64'hFFFFFFFF_FFFFFFEC);

    // non-MULT commands and bubbles
    prior = {hi, lo};
    exe_cmd = ADD; valid = 1; val1 = 3; val2 = 4;
    for (int k = 0; k < 5; k++) begin
      #1 chk("add_no_stall", {62'b0, stall, done}, 64'd0);
      tick();
    end
    exe_cmd = MULT; valid = 0;
    #1 chk("bubble_no_stall", {63'b0, stall}, 64'd0);
    tick();
    chk("hilo_untouched", {hi, lo}, prior);

    // reset mid-RUN
    exe_cmd = MULT; valid = 1; val1 = 123; val2 = 456;
    tick();
    for (int k = 0; k < 5; k++) tick();
    rst = 1; valid = 0;
    tick();
    rst = 0;
    #1 chk("rst_mid_hilo", {hi, lo}, 64'd0);
    chk("rst_mid_flags", {62'b0, stall, done}, 64'd0);
    for (int k = 0; k < 36; k++) begin
      if (done) chk("no_done_after_rst", 64'd1, 64'd0);
      tick();
    end
    run_mult(32'hDEADBEEF, 32'h12345678, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exe_mult_unit.md
Name: exe_mult_unit

Overview:
- Iterative signed multiplier in the EXE stage, directly downstream of the ID-stage controller.
- Executes EXE_MULT commands. The controller issues these with WB_EN=0, so the 64-bit product goes to dedicated HI/LO registers inside this block, not to the register file.
- Holds the pipeline with `stall` while an operation is in flight.

Parameters:
- WORD_LEN, 32: operand width; the product is 2*WORD_LEN bits.
- EXE_CMD_LEN, 4: width of exe_cmd.
- MULT_CMD, 4'd10: exe_cmd encoding that starts a multiply. Instantiated with `EXE_MULT.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- exe_cmd  in  EXE_CMD_LEN  EXE command of the instruction currently in EXE.
- valid  in  1  EXE-stage instruction is valid (not a bubble).
- flush  in  1  kill the in-flight multiply (branch taken).
- val1  in  WORD_LEN  multiplicand, two's complement.
- val2  in  WORD_LEN  multiplier, two's complement.
- stall  out  1  freeze IF/ID/EXE pipeline registers.
- done  out  1  one-cycle pulse; HI/LO hold the new product.
- hi  out  WORD_LEN  upper half of the last product.
- lo  out  WORD_LEN  lower half of the last product.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, hi=0, lo=0, count=0.
  - stall=0, done=0.
  - rst dominates flush and start.
- start is defined as: valid & (exe_cmd==MULT_CMD) & ~flush.
- States: IDLE, RUN, DONE.
- IDLE:
  - stall = start (combinational, same cycle, so the MULT stays in EXE).
  - On start at the edge: capture mcand = |val1| (2*WORD_LEN bits) and mplier = |val2| (WORD_LEN bits).
  - At the same edge: neg = val1[MSB]^val2[MSB], acc=0, count=0, go to RUN.
  - |-2^(WORD_LEN-1)| = 2^(WORD_LEN-1) and is represented unsigned; no overflow.
- RUN:
  - stall=1.
  - Each cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, count++.
  - After exactly WORD_LEN RUN cycles, at the last edge: {hi,lo} = neg ? -(final acc) : final acc. Go to DONE.
  - The final acc includes the last partial product.
- DONE:
  - done=1, stall=0. The pipeline advances the MULT out of EXE at this edge.
  - A start condition is ignored in DONE. Next state is always IDLE.
- Latency: accept cycle + WORD_LEN RUN cycles + DONE cycle.
  - A MULT occupies EXE for WORD_LEN+2 cycles.
  - stall is high for WORD_LEN+1 consecutive cycles.
- Back-to-back MULTs: the second arrives in the cycle after DONE and is accepted from IDLE with no extra bubble.
- flush:
  - In RUN or on the accept cycle: return to IDLE at the edge. hi/lo are unchanged, done stays 0.
  - stall deasserts combinationally in the flush cycle.
  - flush in DONE has no effect; hi/lo are already committed.
- Commands other than MULT_CMD, or valid=0: no state change, stall=0.
- hi/lo change only on the RUN→DONE edge or on reset.
- Operands are sampled only on the accept edge; val1/val2 changes during RUN are ignored.
- Arithmetic is modulo 2^(2*WORD_LEN) on acc.

Test Plan:
- Reset, then val1=3, val2=5, MULT, valid=1:
  - stall high for exactly 33 cycles; done pulses on cycle 34.
  - hi=0x00000000, lo=0x0000000F.
- val1=-2 (0xFFFFFFFE), val2=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- val1=val2=0x80000000 → hi=0x40000000, lo=0x00000000.
- val1=0x7FFFFFFF, val2=0xFFFFFFFF (-1) → hi=0xFFFFFFFF, lo=0x80000001.
- Start 7*9, then assert flush on the 10th RUN cycle:
  - stall low in that cycle; state IDLE next; no done pulse.
  - hi/lo keep the prior product.
- Two MULTs back-to-back (6*7 then -4*5):
  - first done → lo=42; next cycle accepts the second.
  - second done → hi=0xFFFFFFFF, lo=0xFFFFFFEC.
- rst=1 mid-RUN → next cycle hi=lo=0, stall=0, done=0.
- exe_cmd=ADD with valid=1 → stall stays 0 and hi/lo are untouched.
